imem_fetch_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch interface. It serves fetch requests issued by the fetch stage of the multi-cycle/pipelined core.
- Accepts one word-aligned PC per request and returns the instruction after a fixed LATENCY, using valid/ready handshakes on both the request and response sides.
- Supports a redirect flush and a loader write port used by the bench and boot code to fill memory.

---
 rtl/imem_fetch_responder.sv | 131 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: serves one word-aligned fetch per request after a fixed LATENCY.
// Optional statistics counters are compiled in with IMEM_STATS_EN.
module imem_fetch_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_pc,
  output logic        resp_err,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] stat_fetch_cnt,
  output logic [31:0] stat_stall_cnt
);
  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       resp_inst_q, resp_pc_q;
  logic              resp_err_q;
  logic [31:0]       pend_pc_q;
  logic              pend_err_q;
  logic [AW-1:0]     pend_idx_q;

  logic              accept, req_err;
  logic [AW-1:0]     req_idx;

  assign req_ready  = !flush && (state_q == IDLE || (state_q == RESP && resp_ready));
  assign resp_valid = (state_q == RESP) && !flush;
  assign accept     = req_valid && req_ready;
  assign req_idx    = req_addr[AW+1:2];
  assign req_err    = (req_addr[1:0] != 2'b00) ||
                      ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign resp_inst = resp_inst_q;
  assign resp_pc   = resp_pc_q;
  assign resp_err  = resp_err_q;

  // Loader port wraps on the word index and is live in every state, even in reset.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr[AW+1:2]] <= ld_data;
  end

  logic unused_ld_bits;
  assign unused_ld_bits = ^{ld_addr[1:0], ld_addr[31:AW+2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      resp_inst_q <= '0;
      resp_pc_q   <= '0;
      resp_err_q  <= 1'b0;
      pend_pc_q   <= '0;
      pend_err_q  <= 1'b0;
      pend_idx_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            // Memory is sampled on the edge entering RESP (read-before-write vs ld_we).
            if (LATENCY == 1) begin
              state_q     <= RESP;
              resp_pc_q   <= req_addr;
              resp_err_q  <= req_err;
              resp_inst_q <= req_err ? NOP_INST : mem[req_idx];
            end else begin
              state_q    <= WAIT;
              cnt_q      <= LAT_M1;
              pend_pc_q  <= req_addr;
              pend_err_q <= req_err;
              pend_idx_q <= req_idx;
            end
          end else if (state_q == RESP && resp_ready) begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            resp_pc_q   <= pend_pc_q;
            resp_err_q  <= pend_err_q;
            resp_inst_q <= pend_err_q ? NOP_INST : mem[pend_idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IMEM_STATS_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (resp_valid && resp_ready)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (resp_valid && !resp_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_fetch_cnt = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_imem_fetch_responder;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, resp_ready = 1'b1, flush = 1'b0, ld_we = 1'b0;
  logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_inst, resp_pc, stat_fetch_cnt, stat_stall_cnt;

`ifdef IMEM_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  imem_fetch_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_pc(resp_pc), .resp_err(resp_err),
    .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .stat_fetch_cnt(stat_fetch_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every completed transfer must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got pc %h expected no response", resp_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_inst", resp_inst, e.inst);
        chk("resp_pc",   resp_pc,   e.pc);
        chk("resp_err",  {31'b0, resp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // Issue one request; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] a, input bit push, input logic [31:0] inst, input bit err);
    int k;
    req_valid = 1'b1; req_addr = a;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout: got req_ready 0 expected 1 for addr %h", a);
    end else if (push) begin
      sb.push_back('{inst: inst, pc: a, err: err});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 50) begin @(negedge clk); k++; end
    if (!resp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL resp_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin @(posedge clk); #1; k++; end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic quiet(input string nm, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk(nm, {31'b0, seen}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [31:0] insts [3];
    logic [31:0] s_inst, s_pc;
    logic        s_err;
    addrs = '{32'h4, 32'h8, 32'hC};
    insts = '{32'h00A00113, 32'h002081B3, 32'h00000013};

    // Memory loaded while reset is held high.
    reset = 1'b1;
    load(32'h0, 32'h00500093);
    load(32'h4, 32'h00A00113);
    load(32'h8, 32'h002081B3);
    load(32'hC, 32'h00000013);
    reset = 1'b0;

    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_inst",  resp_inst, 32'd0);
    chk("rst_resp_pc",    resp_pc,   32'd0);
    chk("rst_resp_err",   {31'b0, resp_err}, 32'd0);
    chk("rst_fetch_cnt",  stat_fetch_cnt, 32'd0);
    chk("rst_stall_cnt",  stat_stall_cnt, 32'd0);
    @(posedge clk); #1;

    // First fetch: response visible exactly LATENCY cycles after accept.
    send(32'h0, 1'b1, 32'h00500093, 1'b0);
    @(negedge clk);
    chk("lat_early_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Back-to-back with req_valid held high.
    for (int i = 0; i < 3; i++) begin
      int k;
      req_valid = 1'b1; req_addr = addrs[i];
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin @(negedge clk); k++; end
      if (!req_ready) begin
        n_tests++; n_fail++;
        $display("FAIL b2b_accept_timeout: got req_ready 0 expected 1");
      end else begin
        if (i > 0) chk("b2b_overlap_valid", {31'b0, resp_valid}, 32'd1);
        sb.push_back('{inst: insts[i], pc: addrs[i], err: 1'b0});
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();

    // Error responses.
    send(32'h6,    1'b1, 32'h00000013, 1'b1);
    send(32'h1000, 1'b1, 32'h00000013, 1'b1);
    drain();

    // Stall for three cycles, then transfer.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    resp_ready = 1'b0;
    send(32'h4, 1'b1, 32'h00A00113, 1'b0);
    wait_valid();
    s_inst = resp_inst; s_pc = resp_pc; s_err = resp_err;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_inst",  resp_inst, s_inst);
      chk("stall_pc",    resp_pc,   s_pc);
      chk("stall_err",   {31'b0, resp_err}, {31'b0, s_err});
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("stat_stall_cnt", stat_stall_cnt, STATS_ON ? 32'd3 : 32'd0);
    chk("stat_fetch_cnt", stat_fetch_cnt, STATS_ON ? 32'd1 : 32'd0);
    drain();

    // Flush during WAIT.
    send(32'h4, 1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    quiet("flush_wait_no_valid", 4);
    send(32'h8, 1'b1, 32'h002081B3, 1'b0);
    drain();

    // Flush during RESP.
    resp_ready = 1'b0;
    send(32'h4, 1'b0, 32'h0, 1'b0);
    wait_valid();
    @(posedge clk); #1;
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    chk("flush_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    quiet("flush_resp_no_valid", 4);
    send(32'h8, 1'b1, 32'h002081B3, 1'b0);
    drain();

    // Reset during RESP abandons the response; memory survives.
    resp_ready = 1'b0;
    send(32'hC, 1'b0, 32'h0, 1'b0);
    wait_valid();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rrst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rrst_resp_inst",  resp_inst, 32'd0);
    chk("rrst_resp_pc",    resp_pc,   32'd0);
    chk("rrst_resp_err",   {31'b0, resp_err}, 32'd0);
    chk("rrst_stall_cnt",  stat_stall_cnt, 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    send(32'h0, 1'b1, 32'h00500093, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
